// File: rtl/int_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : int_multiplier
// Purpose  : Iterative radix-2^m RV32M multiplier (MUL/MULH/MULHSU/MULHU) with
//            valid/ready handshake and back-to-back product reuse.
// Revision : 1.0 - initial release
// ============================================================================
module int_multiplier #(
    parameter int n = 32,
    parameter int m = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_in,
    output logic         ready_out,
    output logic         valid_out,
    input  logic         ready_in,
    input  logic [1:0]   op,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] y
);

    localparam int STEPS = n / m;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [1:0]    c_OP_MUL    = 2'b00;
    localparam logic [1:0]    c_OP_MULH   = 2'b01;
    localparam logic [1:0]    c_OP_MULHSU = 2'b10;
    localparam logic [CW-1:0] c_CNT_LAST  = CW'(STEPS - 1);
    localparam logic [CW-1:0] c_CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] c_CNT_ZERO  = '0;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_t;

    state_t          state_q,   state_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [2*n-1:0]  acc_q,     acc_d;
    logic [2*n-1:0]  mcand_q,   mcand_d;
    logic [n-1:0]    bmag_q,    bmag_d;
    logic            sgn_q,     sgn_d;
    logic [1:0]      op_q,      op_d;
    logic [2*n-1:0]  prod_q,    prod_d;
    logic            valid_q,   valid_d;
    logic            reuse_q,   reuse_d;
    logic [n-1:0]    prev_a_q,  prev_a_d;
    logic [n-1:0]    prev_b_q,  prev_b_d;
    logic [1:0]      prev_op_q, prev_op_d;

    logic            accept;
    logic            reuse_hit;
    logic            a_neg;
    logic            b_neg;
    logic [n-1:0]    a_mag;
    logic [n-1:0]    b_mag;
    logic [2*n-1:0]  partial;
    logic [2*n-1:0]  acc_sum;

    assign ready_out = (state_q == S_IDLE) && (!valid_q || ready_in);
    assign accept    = valid_in && ready_out;
    assign valid_out = valid_q;
    assign y         = (op_q == c_OP_MUL) ? prod_q[n-1:0] : prod_q[2*n-1:n];

    // The low half of a product does not depend on operand signedness.
    assign reuse_hit = reuse_q && (a == prev_a_q) && (b == prev_b_q) &&
                       ((op == c_OP_MUL) || (op == prev_op_q));

    assign a_neg = ((op == c_OP_MULH) || (op == c_OP_MULHSU)) && a[n-1];
    assign b_neg = (op == c_OP_MULH) && b[n-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // mcand_q is |a| pre-shifted to the current digit position.
    assign partial = mcand_q * {{(2*n-m){1'b0}}, bmag_q[m-1:0]};
    assign acc_sum = acc_q + partial;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        bmag_d    = bmag_q;
        sgn_d     = sgn_q;
        op_d      = op_q;
        prod_d    = prod_q;
        valid_d   = valid_q;
        reuse_d   = reuse_q;
        prev_a_d  = prev_a_q;
        prev_b_d  = prev_b_q;
        prev_op_d = prev_op_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d      = op;
                    prev_a_d  = a;
                    prev_b_d  = b;
                    prev_op_d = op;
                    if (reuse_hit) begin
                        valid_d = 1'b1;
                    end else begin
                        state_d = S_CALC;
                        cnt_d   = c_CNT_ZERO;
                        acc_d   = '0;
                        mcand_d = {{n{1'b0}}, a_mag};
                        bmag_d  = b_mag;
                        sgn_d   = a_neg ^ b_neg;
                        valid_d = 1'b0;
                        reuse_d = 1'b0;
                    end
                end else if (valid_q && ready_in) begin
                    valid_d = 1'b0;
                end
            end
            S_CALC: begin
                acc_d   = acc_sum;
                mcand_d = mcand_q << m;
                bmag_d  = bmag_q >> m;
                cnt_d   = cnt_q + c_CNT_ONE;
                if (cnt_q == c_CNT_LAST) begin
                    prod_d  = sgn_q ? -acc_sum : acc_sum;
                    valid_d = 1'b1;
                    reuse_d = 1'b1;
                    cnt_d   = c_CNT_ZERO;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            bmag_q    <= '0;
            sgn_q     <= 1'b0;
            op_q      <= c_OP_MUL;
            prod_q    <= '0;
            valid_q   <= 1'b0;
            reuse_q   <= 1'b0;
            prev_a_q  <= '0;
            prev_b_q  <= '0;
            prev_op_q <= c_OP_MUL;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            bmag_q    <= bmag_d;
            sgn_q     <= sgn_d;
            op_q      <= op_d;
            prod_q    <= prod_d;
            valid_q   <= valid_d;
            reuse_q   <= reuse_d;
            prev_a_q  <= prev_a_d;
            prev_b_q  <= prev_b_d;
            prev_op_q <= prev_op_d;
        end
    end

endmodule
`default_nettype wire
